// File: rtl/keypad_matrix_emulator.sv
// keypad_matrix_emulator
//   Device-side model of a 4x4 active-low matrix keypad. A keypad scanner
//   drives the row strobes and reads the column returns. Each requested key
//   change is turned into a bounce window in which the affected contact
//   follows a 16-bit LFSR. After the window the change is committed to the
//   clean key state. Only one key changes at a time, lowest index first.
//
// Ports
//   clk          in   1   system clock
//   RSTn         in   1   synchronous reset, active-low
//   key_req      in   16  requested key state, bit k = row k/4, col k%4, 1 = pressed
//   row          in   4   scanner row strobes, active-low
//   col          out  4   column returns, active-low, registered
//   key_settled  out  16  committed clean key state
//   busy         out  1   high while a transition is bouncing or committing
module keypad_matrix_emulator #(
  parameter int unsigned BOUNCE_CYC = 50000,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic        clk,
  input  logic        RSTn,
  input  logic [15:0] key_req,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  output logic [15:0] key_settled,
  output logic        busy
);

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam int unsigned CNT_W = (BOUNCE_CYC > 1) ? $clog2(BOUNCE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = (BOUNCE_CYC > 0) ? CNT_W'(BOUNCE_CYC - 1) : '0;

  typedef enum logic [1:0] {IDLE, BOUNCE, COMMIT} state_t;

  state_t            state;
  state_t            state_next;
  logic [15:0]       key_req_q;
  logic [15:0]       diff;
  logic [3:0]        low_idx;
  logic [3:0]        idx;
  logic              tgt;
  logic [CNT_W-1:0]  cnt;
  logic [15:0]       lfsr;
  logic [15:0]       lfsr_next;
  logic [15:0]       contact;
  logic [3:0]        col_next;

  assign diff = key_req_q ^ key_settled;

  // Taps 16,14,13,11: the feedback bit enters at bit 0 as the register shifts left.
  assign lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

  // Lowest differing key index. The descending scan lets the lowest set bit win.
  always_comb begin
    low_idx = '0;
    for (int k = 15; k >= 0; k--) begin
      if (diff[k]) low_idx = 4'(k);
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!RSTn) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic. A zero-length bounce window goes straight to COMMIT.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (diff != '0) state_next = (BOUNCE_CYC == 0) ? COMMIT : BOUNCE;
      BOUNCE:  if (cnt == '0) state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic. The bouncing contact follows the LFSR. All other contacts
  // show the committed state.
  always_comb begin
    busy    = (state != IDLE);
    contact = key_settled;
    if (state == BOUNCE) contact[idx] = lfsr[0];
  end

  // Ideal diode matrix. A column is pulled low by any pressed contact on any
  // selected row. Idle rows contribute nothing.
  always_comb begin
    col_next = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!row[r] && contact[4*r+c]) col_next[c] = 1'b0;
      end
    end
  end

  // Datapath: request capture, transition latch, bounce timer, LFSR, commit,
  // and the registered column drive.
  always_ff @(posedge clk) begin
    if (!RSTn) begin
      key_req_q   <= '0;
      key_settled <= '0;
      lfsr        <= SEED;
      cnt         <= '0;
      idx         <= '0;
      tgt         <= 1'b0;
      col         <= 4'hF;
    end else begin
      key_req_q <= key_req;
      col       <= col_next;
      case (state)
        IDLE: begin
          if (diff != '0) begin
            idx <= low_idx;
            tgt <= key_req_q[low_idx];
            cnt <= CNT_LOAD;
          end
        end
        BOUNCE: begin
          lfsr <= lfsr_next;
          if (cnt != '0) cnt <= cnt - CNT_W'(1);
        end
        COMMIT:  key_settled[idx] <= tgt;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_matrix_emulator.sv
// tb_keypad_matrix_emulator
//   Runs two emulators side by side on the same stimulus. One uses an
//   8-cycle bounce window. The other has no bounce and a zero seed.
//   A transaction-level keypad model predicts col, key_settled and busy.
//   The model tracks each key change as one window of N bounce cycles
//   followed by one commit cycle.
module tb_keypad_matrix_emulator;

  localparam int          L_A    = 8;
  localparam int          L_Z    = 0;
  localparam logic [15:0] SEED_A = 16'hACE1;
  localparam logic [15:0] SEED_Z = 16'h0001;

  logic        clk;
  logic        rst_n;
  logic [15:0] key_req;
  logic [3:0]  row;
  logic [3:0]  col_a, col_z;
  logic [15:0] set_a, set_z;
  logic        busy_a, busy_z;

  int checks = 0;
  int errors = 0;

  keypad_matrix_emulator #(.BOUNCE_CYC(L_A), .LFSR_SEED(16'hACE1)) dut_a (
    .clk(clk), .RSTn(rst_n), .key_req(key_req), .row(row),
    .col(col_a), .key_settled(set_a), .busy(busy_a));

  keypad_matrix_emulator #(.BOUNCE_CYC(L_Z), .LFSR_SEED(16'h0000)) dut_z (
    .clk(clk), .RSTn(rst_n), .key_req(key_req), .row(row),
    .col(col_z), .key_settled(set_z), .busy(busy_z));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model, index 0 = dut_a, 1 = dut_z
  logic [15:0] m_req[2];
  logic [15:0] m_set[2];
  logic [15:0] m_lfsr[2];
  logic [3:0]  m_col[2];
  bit          m_act[2];
  int          m_left[2];
  int          m_idx[2];
  logic        m_tgt[2];
  logic [15:0] m_contact;
  logic [15:0] m_diff;

  // Each posedge: compute the column returns from the current contacts,
  // then advance any active transaction or start a new one.
  task model_step();
    for (int m = 0; m < 2; m++) begin
      if (!rst_n) begin
        m_req[m]  = '0;
        m_set[m]  = '0;
        m_lfsr[m] = (m == 0) ? SEED_A : SEED_Z;
        m_col[m]  = 4'hF;
        m_act[m]  = 0;
        m_left[m] = 0;
        m_idx[m]  = 0;
        m_tgt[m]  = 1'b0;
      end else begin
        m_contact = m_set[m];
        if (m_act[m] && m_left[m] > 1) m_contact[m_idx[m]] = m_lfsr[m][0];
        m_col[m] = 4'hF;
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++)
            if (row[r] == 1'b0 && m_contact[4*r+c] == 1'b1) m_col[m][c] = 1'b0;
        if (m_act[m]) begin
          if (m_left[m] > 1) begin
            m_lfsr[m] = {m_lfsr[m][14:0], ^(m_lfsr[m] & 16'hB400)};
            m_left[m] = m_left[m] - 1;
          end else begin
            m_set[m][m_idx[m]] = m_tgt[m];
            m_act[m] = 0;
          end
        end else begin
          m_diff = m_req[m] ^ m_set[m];
          if (m_diff != 0) begin
            for (int k = 0; k < 16; k++) begin
              if (m_diff[k]) begin
                m_idx[m] = k;
                break;
              end
            end
            m_tgt[m]  = m_req[m][m_idx[m]];
            m_act[m]  = 1;
            m_left[m] = ((m == 0) ? L_A : L_Z) + 1;
          end
        end
        m_req[m] = key_req;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Waits (bounded) until busy of the selected instance reaches a level.
  task automatic wait_busy(input bit use_z, input logic level, input int max_cyc, output bit ok);
    int n;
    n  = 0;
    ok = 1;
    while (((use_z ? busy_z : busy_a)) !== level) begin
      if (n >= max_cyc) begin
        ok = 0;
        return;
      end
      @(negedge clk);
      n++;
    end
  endtask

  // Releases all keys and waits (bounded) until both instances are idle and empty.
  task automatic settle(output bit ok);
    int n;
    key_req = '0;
    n  = 0;
    ok = 1;
    @(negedge clk);
    while (busy_a || busy_z || set_a != 0 || set_z != 0) begin
      if (n >= 100) begin
        ok = 0;
        return;
      end
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    key_req = 16'h0010;
    row     = 4'h0;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ({col_a, set_a, busy_a} !== {4'hF, 16'h0, 1'b0}) begin
        errors++;
        $display("[TB] FAIL reset_a: got col=%h set=%h busy=%b, expected col=f set=0000 busy=0", col_a, set_a, busy_a);
      end
      checks++;
      if ({col_z, set_z, busy_z} !== {4'hF, 16'h0, 1'b0}) begin
        errors++;
        $display("[TB] FAIL reset_z: got col=%h set=%h busy=%b, expected col=f set=0000 busy=0", col_z, set_z, busy_z);
      end
    end
    key_req = '0;
    rst_n   = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_press_key5();
    key_req = 16'h0020;
    row     = 4'b1101;
    @(negedge clk);
    checks++;
    if (busy_a !== 1'b0) begin
      errors++;
      $display("[TB] FAIL key5_busy_early: got %b expected 0", busy_a);
    end
    @(negedge clk);
    checks++;
    if (busy_a !== 1'b1) begin
      errors++;
      $display("[TB] FAIL key5_busy_rise: got %b expected 1", busy_a);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({col_a, set_a, busy_a} !== {m_col[0], m_set[0], m_act[0]}) begin
        errors++;
        $display("[TB] FAIL key5_bounce cyc %0d: got col=%h set=%h busy=%b, expected col=%h set=%h busy=%b",
                 i, col_a, set_a, busy_a, m_col[0], m_set[0], m_act[0]);
      end
    end
    checks++;
    if ({col_a, set_a, busy_a} !== {4'b1101, 16'h0020, 1'b0}) begin
      errors++;
      $display("[TB] FAIL key5_settled: got col=%h set=%h busy=%b, expected col=d set=0020 busy=0", col_a, set_a, busy_a);
    end
    row = 4'b1110;
    @(negedge clk);
    checks++;
    if (col_a !== 4'hF) begin
      errors++;
      $display("[TB] FAIL key5_other_row: got col=%h expected f", col_a);
    end
  endtask

  task automatic test_simultaneous();
    bit ok;
    settle(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL simul_settle: got timeout expected idle");
    end
    key_req = 16'h8001;
    row     = 4'b0110;
    wait_busy(0, 1'b1, 5, ok);
    wait_busy(0, 1'b0, 20, ok);
    checks++;
    if (!ok || set_a !== 16'h0001) begin
      errors++;
      $display("[TB] FAIL simul_first: got set=%h ok=%b expected set=0001", set_a, ok);
    end
    @(negedge clk);
    checks++;
    if (busy_a !== 1'b1) begin
      errors++;
      $display("[TB] FAIL simul_gap: got busy=%b expected 1 after one idle cycle", busy_a);
    end
    wait_busy(0, 1'b0, 20, ok);
    checks++;
    if (!ok || set_a !== 16'h8001) begin
      errors++;
      $display("[TB] FAIL simul_second: got set=%h ok=%b expected set=8001", set_a, ok);
    end
    repeat (2) @(negedge clk);
    checks++;
    if ({col_a, col_z, set_z} !== {4'b0110, 4'b0110, 16'h8001}) begin
      errors++;
      $display("[TB] FAIL simul_cols: got col_a=%h col_z=%h set_z=%h, expected 6 6 8001", col_a, col_z, set_z);
    end
  endtask

  task automatic test_release_mid_bounce();
    bit ok;
    settle(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL release_settle: got timeout expected idle");
    end
    key_req = 16'h0008;
    wait_busy(0, 1'b1, 5, ok);
    repeat (2) @(negedge clk);
    key_req = 16'h0000;
    wait_busy(0, 1'b0, 20, ok);
    checks++;
    if (!ok || set_a !== 16'h0008) begin
      errors++;
      $display("[TB] FAIL release_commit1: got set=%h ok=%b expected 0008", set_a, ok);
    end
    wait_busy(0, 1'b1, 3, ok);
    wait_busy(0, 1'b0, 20, ok);
    checks++;
    if (!ok || set_a !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL release_commit2: got set=%h ok=%b expected 0000", set_a, ok);
    end
    row = 4'b1110;
    repeat (2) @(negedge clk);
    checks++;
    if (col_a !== 4'hF) begin
      errors++;
      $display("[TB] FAIL release_col: got col=%h expected f", col_a);
    end
  endtask

  task automatic test_reset_mid_bounce();
    bit ok;
    settle(ok);
    key_req = 16'h0040;
    row     = 4'b1101;
    wait_busy(0, 1'b1, 5, ok);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({col_a, set_a, busy_a, set_z} !== {4'hF, 16'h0, 1'b0, 16'h0}) begin
      errors++;
      $display("[TB] FAIL reset_mid: got col=%h set=%h busy=%b set_z=%h, expected f 0000 0 0000",
               col_a, set_a, busy_a, set_z);
    end
    key_req = 16'h0000;
    rst_n   = 1'b1;
    @(negedge clk);
    // A fresh press must bounce with the freshly seeded LFSR.
    key_req = 16'h0040;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      checks++;
      if ({col_a, set_a, busy_a} !== {m_col[0], m_set[0], m_act[0]}) begin
        errors++;
        $display("[TB] FAIL reseed cyc %0d: got col=%h set=%h busy=%b, expected col=%h set=%h busy=%b",
                 i, col_a, set_a, busy_a, m_col[0], m_set[0], m_act[0]);
      end
    end
  endtask

  task automatic test_no_bounce();
    bit          ok;
    logic [15:0] exp_set[4]  = '{16'h0000, 16'h0000, 16'h0400, 16'h0400};
    logic        exp_busy[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [3:0]  exp_col[4]  = '{4'hF, 4'hF, 4'hF, 4'b1011};
    settle(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL nobounce_settle: got timeout expected idle");
    end
    row     = 4'b1011;
    key_req = 16'h0400;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({col_z, set_z, busy_z} !== {exp_col[i], exp_set[i], exp_busy[i]}) begin
        errors++;
        $display("[TB] FAIL nobounce cyc %0d: got col=%h set=%h busy=%b, expected col=%h set=%h busy=%b",
                 i, col_z, set_z, busy_z, exp_col[i], exp_set[i], exp_busy[i]);
      end
    end
  endtask

  task automatic test_random_traffic();
    int k;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      checks++;
      if ({col_a, set_a, busy_a} !== {m_col[0], m_set[0], m_act[0]}) begin
        errors++;
        $display("[TB] FAIL random_a cyc %0d: got col=%h set=%h busy=%b, expected col=%h set=%h busy=%b",
                 i, col_a, set_a, busy_a, m_col[0], m_set[0], m_act[0]);
      end
      checks++;
      if ({col_z, set_z, busy_z} !== {m_col[1], m_set[1], m_act[1]}) begin
        errors++;
        $display("[TB] FAIL random_z cyc %0d: got col=%h set=%h busy=%b, expected col=%h set=%h busy=%b",
                 i, col_z, set_z, busy_z, m_col[1], m_set[1], m_act[1]);
      end
      if ($urandom_range(0, 7) == 0) begin
        k = $urandom_range(0, 15);
        key_req[k] = ~key_req[k];
      end
      row   = 4'($urandom_range(0, 15));
      rst_n = ($urandom_range(0, 249) == 0) ? 1'b0 : 1'b1;
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n   = 1'b0;
    key_req = '0;
    row     = 4'hF;
    test_reset();
    test_press_key5();
    test_simultaneous();
    test_release_mid_bounce();
    test_reset_mid_bounce();
    test_no_bounce();
    test_random_traffic();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
